// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sram_port_arbiter : two-requester arbiter onto one single-port SRAM, one
// outstanding access. Option macro SRAM_ARB_FIXED_PRIO_EN. Revision: 1.0
// ============================================================================
module sram_port_arbiter #(
    parameter int DATAW = 32,
    parameter int ADDRW = 7
) (
    input  logic                   clk,
    input  logic                   rstx,
    input  logic [1:0]             req_avalid,
    output logic [1:0]             req_aready,
    input  logic [2*DATAW-1:0]     req_adata,
    input  logic [2*ADDRW-1:0]     req_aaddr,
    input  logic [1:0]             req_awren,
    input  logic [2*DATAW/8-1:0]   req_astrb,
    output logic [1:0]             req_rvalid,
    input  logic [1:0]             req_rready,
    output logic [DATAW-1:0]       req_rdata,
    output logic                   mem_avalid,
    input  logic                   mem_aready,
    output logic [DATAW-1:0]       mem_adata,
    output logic [ADDRW-1:0]       mem_aaddr,
    output logic                   mem_awren,
    output logic [DATAW/8-1:0]     mem_astrb,
    input  logic                   mem_rvalid,
    output logic                   mem_rready,
    input  logic [DATAW-1:0]       mem_rdata
);

    localparam int STRBW = DATAW / 8;

    logic r_pending;
    logic r_owner;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic r_last;
`endif

    logic w_consume;
    logic w_permit;
    logic w_sel;
    logic w_accept;
    logic w_rv;

    always_comb begin
        w_consume = r_pending & mem_rvalid & req_rready[r_owner];
        // A new grant may overlap the cycle that retires the outstanding response
        w_permit  = rstx & (~r_pending | w_consume);
        w_sel     = req_avalid[1];
        if (req_avalid == 2'b11) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            w_sel = 1'b0;
`else
            w_sel = ~r_last;
`endif
        end
        mem_avalid = w_permit & (|req_avalid);
        w_accept   = mem_avalid & mem_aready;
        req_aready = 2'b00;
        if (w_accept) begin
            req_aready = w_sel ? 2'b10 : 2'b01;
        end
        mem_adata  = w_sel ? req_adata[DATAW +: DATAW] : req_adata[0 +: DATAW];
        mem_aaddr  = w_sel ? req_aaddr[ADDRW +: ADDRW] : req_aaddr[0 +: ADDRW];
        mem_awren  = w_sel ? req_awren[1] : req_awren[0];
        mem_astrb  = w_sel ? req_astrb[STRBW +: STRBW] : req_astrb[0 +: STRBW];
        w_rv       = rstx & r_pending & mem_rvalid;
        req_rvalid = {w_rv & r_owner, w_rv & ~r_owner};
        mem_rready = rstx & r_pending & req_rready[r_owner];
        req_rdata  = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rstx) begin
            r_pending <= 1'b0;
            r_owner   <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            r_last    <= 1'b1;
`endif
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_owner   <= w_sel;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            r_last    <= w_sel;
`endif
        end else if (w_consume) begin
            r_pending <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// Directed table-driven bench for sram_port_arbiter (default round-robin build).
module tb_sram_port_arbiter;

    localparam int DATAW = 32;
    localparam int ADDRW = 7;

    logic              clk = 1'b0;
    logic              rstx;
    logic [1:0]        req_avalid, req_aready, req_awren, req_rvalid, req_rready;
    logic [63:0]       req_adata;
    logic [13:0]       req_aaddr;
    logic [7:0]        req_astrb;
    logic [31:0]       req_rdata, mem_adata, mem_rdata;
    logic              mem_avalid, mem_aready, mem_awren, mem_rvalid, mem_rready;
    logic [6:0]        mem_aaddr;
    logic [3:0]        mem_astrb;

    int n_tests = 0;
    int n_fail  = 0;

    sram_port_arbiter #(.DATAW(DATAW), .ADDRW(ADDRW)) dut (
        .clk(clk), .rstx(rstx),
        .req_avalid(req_avalid), .req_aready(req_aready), .req_adata(req_adata),
        .req_aaddr(req_aaddr), .req_awren(req_awren), .req_astrb(req_astrb),
        .req_rvalid(req_rvalid), .req_rready(req_rready), .req_rdata(req_rdata),
        .mem_avalid(mem_avalid), .mem_aready(mem_aready), .mem_adata(mem_adata),
        .mem_aaddr(mem_aaddr), .mem_awren(mem_awren), .mem_astrb(mem_astrb),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [1:0]  av;
        logic [1:0]  rr;
        logic        ma;
        logic        mrv;
        logic [31:0] mrd;
        logic [1:0]  e_ardy;
        logic [1:0]  e_rv;
        logic        e_mav;
        logic        e_mrr;
        logic [31:0] e_rd;
        logic [6:0]  e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] av, input logic [1:0] rr,
                       input logic ma, input logic mrv, input logic [31:0] mrd,
                       input logic [1:0] e_ardy, input logic [1:0] e_rv,
                       input logic e_mav, input logic e_mrr, input logic [6:0] e_addr);
        vec_t v;
        v.rst = rst; v.av = av; v.rr = rr; v.ma = ma; v.mrv = mrv; v.mrd = mrd;
        v.e_ardy = e_ardy; v.e_rv = e_rv; v.e_mav = e_mav; v.e_mrr = e_mrr;
        v.e_rd = mrd; v.e_addr = e_addr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        bit got;
        // fixed per-requester access attributes
        req_adata  = {32'h12345678, 32'hA0A0A0A0};
        req_aaddr  = {7'h10, 7'h05};
        req_astrb  = {4'b0011, 4'b1111};
        req_awren  = 2'b00;
        rstx = 1'b0; req_avalid = 2'b00; req_rready = 2'b00;
        mem_aready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        //  rst  av     rr     ma  mrv  mrd            ardy   rv     mav  mrr  addr
        add(0, 2'b11, 2'b11, 1, 1, 32'h0,         2'b00, 2'b00, 0, 0, 7'h00); // in reset
        add(1, 2'b01, 2'b11, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 7'h05); // req0 read
        add(1, 2'b00, 2'b11, 1, 1, 32'hDEADBEEF,  2'b00, 2'b01, 0, 1, 7'h00); // response
        add(1, 2'b11, 2'b11, 1, 0, 32'h0,         2'b10, 2'b00, 1, 0, 7'h10); // rr -> 1
        add(1, 2'b11, 2'b11, 1, 1, 32'h00000001,  2'b01, 2'b10, 1, 1, 7'h05);
        add(1, 2'b11, 2'b11, 1, 1, 32'h00000002,  2'b10, 2'b01, 1, 1, 7'h10);
        add(1, 2'b11, 2'b11, 1, 1, 32'h00000003,  2'b01, 2'b10, 1, 1, 7'h05);
        add(1, 2'b10, 2'b00, 1, 1, 32'hCAFE0001,  2'b00, 2'b01, 0, 0, 7'h00); // stall x3
        add(1, 2'b10, 2'b00, 1, 1, 32'hCAFE0001,  2'b00, 2'b01, 0, 0, 7'h00);
        add(1, 2'b10, 2'b00, 1, 1, 32'hCAFE0001,  2'b00, 2'b01, 0, 0, 7'h00);
        add(1, 2'b10, 2'b01, 1, 1, 32'hCAFE0001,  2'b10, 2'b01, 1, 1, 7'h10); // rready rises
        add(1, 2'b11, 2'b11, 0, 1, 32'h00000004,  2'b00, 2'b10, 1, 1, 7'h05); // mem not ready
        add(1, 2'b11, 2'b11, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 7'h05); // retry, still 0
        add(0, 2'b11, 2'b11, 1, 1, 32'h0,         2'b00, 2'b00, 0, 0, 7'h00); // reset mid-flight
        add(1, 2'b00, 2'b11, 1, 1, 32'h55555555,  2'b00, 2'b00, 0, 0, 7'h00); // response dropped
        add(1, 2'b11, 2'b11, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 7'h05); // conflict -> 0
        add(1, 2'b00, 2'b11, 1, 1, 32'h11223344,  2'b00, 2'b01, 0, 1, 7'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            rstx = vecs[i].rst; req_avalid = vecs[i].av; req_rready = vecs[i].rr;
            mem_aready = vecs[i].ma; mem_rvalid = vecs[i].mrv; mem_rdata = vecs[i].mrd;
            #1;
            check($sformatf("v%0d aready", i), {30'd0, req_aready}, {30'd0, vecs[i].e_ardy});
            check($sformatf("v%0d rvalid", i), {30'd0, req_rvalid}, {30'd0, vecs[i].e_rv});
            check($sformatf("v%0d mem_avalid", i), {31'd0, mem_avalid}, {31'd0, vecs[i].e_mav});
            check($sformatf("v%0d mem_rready", i), {31'd0, mem_rready}, {31'd0, vecs[i].e_mrr});
            if (vecs[i].e_rv != 2'b00)
                check($sformatf("v%0d rdata", i), req_rdata, vecs[i].e_rd);
            if (vecs[i].e_mav)
                check($sformatf("v%0d mem_aaddr", i), {25'd0, mem_aaddr}, {25'd0, vecs[i].e_addr});
        end

        // Requester 1 byte-strobed write, memory answers two cycles later
        @(negedge clk);
        req_avalid = 2'b10; req_awren = 2'b10; req_rready = 2'b11;
        mem_aready = 1'b1; mem_rvalid = 1'b0;
        #1;
        check("wr aready", {30'd0, req_aready}, 32'd2);
        check("wr awren", {31'd0, mem_awren}, 32'd1);
        check("wr astrb", {28'd0, mem_astrb}, 32'h3);
        check("wr aaddr", {25'd0, mem_aaddr}, 32'h10);
        check("wr adata", mem_adata, 32'h12345678);
        @(negedge clk);
        req_avalid = 2'b00; req_awren = 2'b00;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            mem_rvalid = (c >= 1);
            #1;
            if (req_rvalid != 2'b00) begin
                got = 1'b1;
                check("wr rvalid", {30'd0, req_rvalid}, 32'd2);
                check("wr rvalid cycle", c, 1);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("wr response timeout", 32'd0, 32'd1);
        @(negedge clk);
        #1;
        check("wr single response", {30'd0, req_rvalid}, 32'd0);
        check("idle mem_rready", {31'd0, mem_rready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter DATAW, default 32, SRAM data width in bits, multiple of 8.
REQ-002 Parameter ADDRW, default 7, SRAM word address width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rstx  input  1  reset, synchronous, active-low.
REQ-005 req_avalid  input  2  per-requester access request; bit i = requester i.
REQ-006 req_aready  output  2  per-requester access accepted this cycle.
REQ-007 req_adata  input  2*DATAW  write data, requester i at [i*DATAW +: DATAW].
REQ-008 req_aaddr  input  2*ADDRW  word address, requester i at [i*ADDRW +: ADDRW].
REQ-009 req_awren  input  2  1 = write, 0 = read.
REQ-010 req_astrb  input  2*DATAW/8  byte write strobes, requester i at [i*DATAW/8 +: DATAW/8].
REQ-011 req_rvalid  output  2  response valid to requester i.
REQ-012 req_rready  input  2  requester i accepts response.
REQ-013 req_rdata  output  DATAW  response data, shared, qualified by req_rvalid.
REQ-014 mem_avalid  output  1  access to SRAM port.
REQ-015 mem_aready  input  1  SRAM accepts access.
REQ-016 mem_adata, mem_aaddr, mem_awren, mem_astrb  output  DATAW/ADDRW/1/DATAW/8  muxed from granted requester.
REQ-017 mem_rvalid  input  1  SRAM response valid.
REQ-018 mem_rready  output  1  response accepted.
REQ-019 mem_rdata  input  DATAW  SRAM read data, one cycle after accepted access, held until next accepted access.

Function
REQ-020 Access accepted for requester i when req_avalid[i] & req_aready[i] at a clk edge; every accepted access (read or write) yields exactly one response.
REQ-021 State: pending (1 bit), owner (1 bit, requester of outstanding response), last (1 bit, last granted requester).
REQ-022 Grant permitted in a cycle only if pending=0, or pending=1 and the outstanding response is consumed in the same cycle (req_rvalid[owner] & req_rready[owner]).
REQ-023 Arbitration when permitted: single requester valid -> granted; both valid -> requester != last granted (round-robin).
REQ-024 mem_avalid = grant permitted & |req_avalid; mem_adata/aaddr/awren/astrb driven from granted requester, don't-care when mem_avalid=0.
REQ-025 req_aready[i] = granted[i] & mem_aready, combinational; never both bits 1.
REQ-026 On accepted access: pending<=1, owner<=i, last<=i, at same edge.
REQ-027 req_rvalid[owner] = pending & mem_rvalid; other bit 0; req_rdata = mem_rdata passthrough.
REQ-028 mem_rready = pending & req_rready[owner]; 0 when pending=0.
REQ-029 Response consumed with no new accept -> pending<=0; consumed and new accept same cycle -> pending stays 1, owner updated.
REQ-030 Latency: request to response minimum 1 cycle; throughput one access per cycle with requesters holding rready=1.
REQ-031 Response stalled (rready=0) -> no new grant; req_rdata held stable, both req_aready 0.
REQ-032 mem_aready=0 with request pending grant -> last unchanged, grant retried next cycle (decision recomputed).

Reset
REQ-033 rstx=0 at clk edge: pending<=0, owner<=0, last<=1 (requester 0 wins first conflict); outputs req_aready=0, req_rvalid=0, mem_avalid=0, mem_rready=0 while rstx=0.
REQ-034 Reset mid-transaction discards outstanding response; no req_rvalid after rstx returns 1 until a new accept.

Configuration
REQ-035 Macro SRAM_ARB_FIXED_PRIO_EN defined: REQ-023 conflict -> requester 0 always granted, last unused; undefined: round-robin per REQ-023.

Verification
REQ-036 Reset, req 0 read addr 0x05 alone, mem_rdata=0xDEADBEEF -> req_aready=2'b01 cycle 0, req_rvalid=2'b01 cycle 1, req_rdata=0xDEADBEEF.
REQ-037 Both requesters valid continuously, rready=2'b11 -> grants alternate 0,1,0,1 (fixed-priority build: 0,0,0,0), one accept per cycle.
REQ-038 Req 1 write addr 0x10 strb 4'b0011 data 0x12345678 -> mem_awren=1, mem_astrb=4'b0011, mem_aaddr=0x10, one response to req 1.
REQ-039 Req 0 read accepted, req_rready[0]=0 for 3 cycles while req 1 valid -> req_aready=0 and req_rdata stable 3 cycles; req 1 granted in the cycle rready[0] rises.
REQ-040 rstx=0 asserted cycle after accept -> req_rvalid stays 2'b00 post-reset; next conflict grants requester 0.
